// File: rtl/cache_pkg.sv
// Shared types, derived sizes and helpers for the set-associative cache tag model.
package cache_pkg;

  // Default configuration: 32-bit addresses, 16-byte lines, 256 sets, 4 ways
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_OFFSET_W = 4;
  localparam int DEF_INDEX_W  = 8;
  localparam int DEF_WAYS     = 4;
  localparam int DEF_CNT_W    = 32;

  // Sizes derived from the default configuration
  localparam int TAG_W = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;
  localparam int SETS  = 1 << DEF_INDEX_W;
  localparam int WAY_W = $clog2(DEF_WAYS);

  // Widest per-set bit vector the popcount helper accepts
  localparam int POP_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU bookkeeping for one set: victim choice and post-access ages.
// Age 0 is most recently used; ages always form a permutation of 0..WAYS-1.
module cache_lru_set
  import cache_pkg::*;
#(
  parameter int WAYS     = DEF_WAYS,
  parameter int WAY_BITS = WAY_W
) (
  input  logic [WAYS-1:0]                valid,
  input  logic [WAYS-1:0][WAY_BITS-1:0]  ages,
  input  logic [WAYS-1:0]                hit,
  output logic [WAY_BITS-1:0]            victim,
  output logic [WAYS-1:0][WAY_BITS-1:0]  next_ages
);

  logic [WAY_BITS-1:0] touch;
  logic [WAY_BITS-1:0] touch_age;

  // Victim: lowest-numbered invalid way, otherwise the way holding the maximum age
  always_comb begin
    victim = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ages[w] == WAY_BITS'(WAYS - 1)) victim = WAY_BITS'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_BITS'(w);
    end
  end

  // Way being touched: the hitting way if any, otherwise the way about to be filled
  always_comb begin
    touch = victim;
    for (int w = 0; w < WAYS; w++) begin
      if (hit[w]) touch = WAY_BITS'(w);
    end
  end

  assign touch_age = ages[touch];

  // Ages younger than the touched way move one step older; touched way becomes youngest
  always_comb begin
    next_ages = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_BITS'(w) == touch) begin
        next_ages[w] = '0;
      end else if (ages[w] < touch_age) begin
        next_ages[w] = ages[w] + WAY_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/sa_cache_stats.sv
// N-way set-associative cache tag model with hit/miss/evict/writeback statistics,
// write-allocate/write-back policy, valid/ready request handshake and a
// one-set-per-cycle flush sequencer. No data storage.
module sa_cache_stats
  import cache_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int WAYS     = DEF_WAYS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [$clog2(WAYS)-1:0]  resp_way,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count,
  output logic [CNT_W-1:0]         evict_count,
  output logic [CNT_W-1:0]         writeback_count
);

  localparam int TAG_BITS = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NUM_SETS = 1 << INDEX_W;
  localparam int WAY_BITS = $clog2(WAYS);

  state_e                                        state;
  logic [INDEX_W-1:0]                            flush_ptr;
  logic [NUM_SETS-1:0][WAYS-1:0]                 valid_bits;
  logic [NUM_SETS-1:0][WAYS-1:0]                 dirty_bits;
  logic [NUM_SETS-1:0][WAYS-1:0][WAY_BITS-1:0]   set_ages;
  logic [TAG_BITS-1:0]                           tags [NUM_SETS][WAYS];

  logic [INDEX_W-1:0]                            idx;
  logic [TAG_BITS-1:0]                           tag;
  logic                                          accept;
  logic [WAYS-1:0]                               hit_vec;
  logic                                          hit;
  logic [WAY_BITS-1:0]                           hit_way;
  logic [WAY_BITS-1:0]                           victim;
  logic [WAY_BITS-1:0]                           fill_way;
  logic [WAYS-1:0][WAY_BITS-1:0]                 next_ages;
  logic [WAYS-1:0]                               flush_wb_vec;
  logic                                          unused_offset;

  // Saturating add: counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Age pattern of a freshly reset or flushed set: age equals way number
  function automatic logic [WAYS-1:0][WAY_BITS-1:0] reset_ages();
    logic [WAYS-1:0][WAY_BITS-1:0] r;
    for (int w = 0; w < WAYS; w++) begin
      r[w] = WAY_BITS'(w);
    end
    return r;
  endfunction

  assign tag           = req_addr[ADDR_W-1 -: TAG_BITS];
  assign idx           = req_addr[OFFSET_W +: INDEX_W];
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_bits[idx][w] && (tags[idx][w] == tag)) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_BITS'(w);
      end
    end
  end

  assign hit          = |hit_vec;
  assign fill_way     = hit ? hit_way : victim;
  assign flush_wb_vec = valid_bits[flush_ptr] & dirty_bits[flush_ptr];

  cache_lru_set #(
    .WAYS     (WAYS),
    .WAY_BITS (WAY_BITS)
  ) u_lru (
    .valid     (valid_bits[idx]),
    .ages      (set_ages[idx]),
    .hit       (hit_vec),
    .victim    (victim),
    .next_ages (next_ages)
  );

  // Tag fill on a miss; tag contents are qualified by valid so they need no reset
  always_ff @(posedge clk) begin
    if (accept && !hit) begin
      tags[idx][victim] <= tag;
    end
  end

  // Control FSM: request lookup/update, flush sequencing, statistics and response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      flush_ptr       <= '0;
      valid_bits      <= '0;
      dirty_bits      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        set_ages[s] <= reset_ages();
      end
      hit_count       <= '0;
      miss_count      <= '0;
      evict_count     <= '0;
      writeback_count <= '0;
      resp_valid      <= 1'b0;
      resp_hit        <= 1'b0;
      resp_way        <= '0;
      flush_done      <= 1'b0;
    end else begin
      resp_valid <= accept;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            resp_hit      <= hit;
            resp_way      <= fill_way;
            set_ages[idx] <= next_ages;
            if (hit) begin
              hit_count <= sat_add(hit_count, CNT_W'(1));
              if (req_write) dirty_bits[idx][hit_way] <= 1'b1;
            end else begin
              miss_count                <= sat_add(miss_count, CNT_W'(1));
              valid_bits[idx][victim]   <= 1'b1;
              dirty_bits[idx][victim]   <= req_write;
              if (valid_bits[idx][victim]) begin
                evict_count <= sat_add(evict_count, CNT_W'(1));
                if (dirty_bits[idx][victim]) begin
                  writeback_count <= sat_add(writeback_count, CNT_W'(1));
                end
              end
            end
          end
          // A request accepted on the same edge is processed above before flushing starts
          if (flush_req) begin
            state     <= FLUSH;
            flush_ptr <= '0;
          end
        end
        FLUSH: begin
          writeback_count <= sat_add(writeback_count,
                                     CNT_W'(popcount(POP_MAX'(flush_wb_vec))));
          valid_bits[flush_ptr] <= '0;
          dirty_bits[flush_ptr] <= '0;
          set_ages[flush_ptr]   <= reset_ages();
          flush_ptr             <= flush_ptr + INDEX_W'(1);
          if (flush_ptr == {INDEX_W{1'b1}}) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_cache_stats.sv
// Testbench for sa_cache_stats: directed scenarios plus random trace, all checked
// against a recency-list cache model kept in the bench.
module tb_sa_cache_stats;
  import cache_pkg::*;

  localparam int AW    = 32;
  localparam int OW    = 4;
  localparam int IW    = 8;
  localparam int NW    = 4;
  localparam int CW    = 32;
  localparam int NSETS = SETS;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_write;
  logic [AW-1:0]     req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_hit;
  logic [WAY_W-1:0]  resp_way;
  logic              flush_req;
  logic              flush_done;
  logic [CW-1:0]     hit_count;
  logic [CW-1:0]     miss_count;
  logic [CW-1:0]     evict_count;
  logic [CW-1:0]     writeback_count;

  sa_cache_stats #(
    .ADDR_W(AW), .OFFSET_W(OW), .INDEX_W(IW), .WAYS(NW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .flush_req(flush_req), .flush_done(flush_done),
    .hit_count(hit_count), .miss_count(miss_count),
    .evict_count(evict_count), .writeback_count(writeback_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit              m_valid [NSETS][NW];
  bit              m_dirty [NSETS][NW];
  logic [TAG_W-1:0] m_tag  [NSETS][NW];
  int              m_order [NSETS][NW];   // ways of each set, most recent first
  logic [31:0]     m_hits, m_miss, m_evict, m_wb;
  int              m_flush_left;          // -1 idle, >0 sets left to flush, 0 done cycle
  int              m_fptr;
  bit              exp_resp_valid, exp_resp_hit, exp_ready, exp_done;
  int              exp_resp_way;
  bit              cmp_on;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_order[s][w] = w;
      end
    end
    m_hits = 0; m_miss = 0; m_evict = 0; m_wb = 0;
    m_flush_left = -1; m_fptr = 0;
    exp_resp_valid = 0; exp_resp_hit = 0; exp_resp_way = 0;
    exp_ready = 1; exp_done = 0;
  endtask

  task automatic model_touch(input int s, input int w);
    int p;
    p = 0;
    for (int i = 0; i < NW; i++) if (m_order[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
    m_order[s][0] = w;
  endtask

  task automatic model_step(input bit v, input bit wr, input logic [31:0] a, input bit f);
    int s, hw, vw;
    logic [TAG_W-1:0] t;
    exp_resp_valid = 0;
    if (m_flush_left < 0) begin
      if (v) begin
        s = int'(a[OW +: IW]);
        t = a[AW-1 -: TAG_W];
        hw = -1;
        for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        exp_resp_valid = 1;
        if (hw >= 0) begin
          m_hits = sat_inc(m_hits);
          if (wr) m_dirty[s][hw] = 1'b1;
          model_touch(s, hw);
          exp_resp_hit = 1; exp_resp_way = hw;
        end else begin
          m_miss = sat_inc(m_miss);
          vw = -1;
          for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) vw = w;
          if (vw < 0) begin
            vw = m_order[s][NW-1];
            m_evict = sat_inc(m_evict);
            if (m_dirty[s][vw]) m_wb = sat_inc(m_wb);
          end
          m_tag[s][vw] = t; m_valid[s][vw] = 1'b1; m_dirty[s][vw] = wr;
          model_touch(s, vw);
          exp_resp_hit = 0; exp_resp_way = vw;
        end
      end
      if (f) begin
        m_flush_left = NSETS; m_fptr = 0;
      end
    end else if (m_flush_left > 0) begin
      for (int w = 0; w < NW; w++) begin
        if (m_valid[m_fptr][w] && m_dirty[m_fptr][w]) m_wb = sat_inc(m_wb);
        m_valid[m_fptr][w] = 0; m_dirty[m_fptr][w] = 0; m_order[m_fptr][w] = w;
      end
      m_fptr++;
      m_flush_left--;
    end else begin
      m_flush_left = -1;
    end
    exp_ready = (m_flush_left < 0);
    exp_done  = (m_flush_left == 0);
  endtask

  // ---------------- checking ----------------
  typedef struct {
    string  name;
    longint act;
    longint exp;
  } lit_t;
  lit_t lit_q[$];
  int n_pass, n_checks;

  task automatic lit(input string name, input longint act, input longint exp);
    lit_t e;
    e.name = name; e.act = act; e.exp = exp;
    lit_q.push_back(e);
  endtask

  // Single compare process: model vs DUT every cycle, plus queued literal expectations
  always @(negedge clk) begin
    lit_t e;
    longint act [9];
    longint exp [9];
    string  nm  [9];
    if (cmp_on) begin
      nm[0] = "resp_valid";  act[0] = resp_valid;      exp[0] = exp_resp_valid;
      nm[1] = "resp_hit";    act[1] = resp_hit;        exp[1] = exp_resp_hit;
      nm[2] = "resp_way";    act[2] = resp_way;        exp[2] = exp_resp_way;
      nm[3] = "req_ready";   act[3] = req_ready;       exp[3] = exp_ready;
      nm[4] = "flush_done";  act[4] = flush_done;      exp[4] = exp_done;
      nm[5] = "hit_count";   act[5] = hit_count;       exp[5] = m_hits;
      nm[6] = "miss_count";  act[6] = miss_count;      exp[6] = m_miss;
      nm[7] = "evict_count"; act[7] = evict_count;     exp[7] = m_evict;
      nm[8] = "wb_count";    act[8] = writeback_count; exp[8] = m_wb;
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (act[i] == exp[i]) n_pass++;
        else $display("FAIL model %s at %0t: got %0d expected %0d", nm[i], $time, act[i], exp[i]);
      end
    end
    while (lit_q.size() > 0) begin
      e = lit_q.pop_front();
      n_checks++;
      if (e.act == e.exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d expected %0d", e.name, $time, e.act, e.exp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input bit v, input bit wr, input logic [31:0] a, input bit f);
    req_valid = v; req_write = wr; req_addr = a; flush_req = f;
    @(posedge clk);
    model_step(v, wr, a, f);
    @(negedge clk);
    req_valid = 0; req_write = 0; flush_req = 0;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    cycle(0, 0, 32'h0, 0);
  endtask

  int low_cycles, done_pulses, way0;
  logic [19:0] tag_pool [6];

  initial begin
    n_pass = 0; n_checks = 0;
    reset = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; flush_req = 0;
    model_reset();
    cmp_on = 1;
    do_reset();
    lit("reset_miss", miss_count, 0);
    lit("reset_ready", req_ready, 1);
    lit("reset_resp_valid", resp_valid, 0);

    // Scenario 1: miss then hit on the same line
    cycle(1, 0, 32'h0000_1000, 0);
    lit("s1_miss_hit", resp_hit, 0);
    lit("s1_miss_count", miss_count, 1);
    way0 = int'(resp_way);
    lit("s1_way", resp_way, 0);
    cycle(1, 0, 32'h0000_100C, 0);
    lit("s1_hit", resp_hit, 1);
    lit("s1_same_way", resp_way, way0);
    lit("s1_hit_count", hit_count, 1);

    // Scenario 2: fill set 0, evict way 0, reload misses
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 32'(i) << 12, 0);
      lit("s2_fill_way", resp_way, i);
      lit("s2_fill_hit", resp_hit, 0);
    end
    lit("s2_evict0", evict_count, 0);
    cycle(1, 0, 32'h0000_4000, 0);
    lit("s2_victim_way", resp_way, 0);
    lit("s2_evict1", evict_count, 1);
    cycle(1, 0, 32'h0000_0000, 0);
    lit("s2_reload_miss", resp_hit, 0);
    lit("s2_miss_count", miss_count, 6);

    // Scenario 3: touching way 0 moves the LRU victim to way 1
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'(i) << 12, 0);
    cycle(1, 0, 32'h0000_0000, 0);
    lit("s3_hit", resp_hit, 1);
    cycle(1, 0, 32'h0000_4000, 0);
    lit("s3_victim_way", resp_way, 1);
    lit("s3_evict", evict_count, 1);
    cycle(1, 0, 32'h0000_0000, 0);
    lit("s3_still_hit", resp_hit, 1);

    // Scenario 4: dirty line evicted produces one writeback
    do_reset();
    cycle(1, 1, 32'h0000_5000, 0);
    lit("s4_store_miss", resp_hit, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'(i) << 12, 0);
    lit("s4_wb", writeback_count, 1);
    lit("s4_evict", evict_count, 1);

    // Scenario 5: flush of two dirty lines
    do_reset();
    cycle(1, 1, 32'h0000_5030, 0);
    cycle(1, 1, 32'h0000_5070, 0);
    low_cycles = 0; done_pulses = 0;
    cycle(0, 0, 32'h0, 1);
    if (!req_ready) low_cycles++;
    for (int i = 0; i < 400; i++) begin
      if (req_ready) break;
      cycle(0, 0, 32'h0, 0);
      if (!req_ready) low_cycles++;
      if (flush_done) done_pulses++;
    end
    lit("s5_ready_low_cycles", low_cycles, 257);
    lit("s5_done_pulses", done_pulses, 1);
    lit("s5_wb", writeback_count, 2);
    cycle(1, 0, 32'h0000_5030, 0);
    lit("s5_after_flush_miss", resp_hit, 0);
    cycle(1, 0, 32'h0000_5070, 1);
    lit("s5_same_cycle_valid", resp_valid, 1);
    lit("s5_same_cycle_miss", miss_count, 4);
    for (int i = 0; i < 300; i++) begin
      if (req_ready) break;
      cycle(0, 0, 32'h0, 0);
    end
    lit("s5_second_flush_end", req_ready, 1);

    // Scenario 6: reset in the middle of a flush
    do_reset();
    cycle(1, 1, 32'h0ABC_0C80, 0);
    cycle(0, 0, 32'h0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 32'h0, 0);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit("s6_no_done", flush_done, 0);
      lit("s6_miss_zero", miss_count, 0);
      lit("s6_wb_zero", writeback_count, 0);
    end
    #1;
    reset = 1'b0;
    cycle(0, 0, 32'h0, 0);
    lit("s6_ready", req_ready, 1);
    cycle(1, 0, 32'h0ABC_0C80, 0);
    lit("s6_line_gone", resp_hit, 0);

    // Random trace over a few sets and tags to exercise hits, evictions and flushes
    do_reset();
    tag_pool[0] = 20'h00000; tag_pool[1] = 20'h00001; tag_pool[2] = 20'h00002;
    tag_pool[3] = 20'hFFFFF; tag_pool[4] = 20'h80000; tag_pool[5] = 20'h12345;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = {tag_pool[$urandom % 6], 8'($urandom % 4), 4'($urandom % 16)};
      cycle(($urandom % 4) != 0, $urandom % 2, a, ($urandom % 500) == 0);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
